irq_controller: RTL and testbench

Interrupt controller that sits directly upstream of the cpu and drives its `irq` input. It collects `NUM_SRC` peripheral interrupt lines and latches rising edges into a pending register. Enabled requests are arbitrated by fixed priority. A single level request with a vector is presented to the cpu, which acknowledges it and later signals end-of-interrupt. Only one interrupt is in service at a time; there is no nesting.

---
 rtl/irq_pkg.sv | 14 +
 rtl/prio_enc.sv | 23 ++
 rtl/irq_controller.sv | 82 ++++++++
 tb/tb_irq_controller.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding and default sizing.
package irq_pkg;

  localparam int NUM_SRC_DEF = 8;
  localparam int VEC_W_DEF   = 3;

  typedef logic [1:0] state_t;

  // 2'b11 is unused and falls back to ST_IDLE
  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_REQ  = 2'b01;
  localparam state_t ST_SVC  = 2'b10;

endpackage

// File: rtl/prio_enc.sv
// Combinational first-one finder: reports the lowest set index and whether any bit is set.
module prio_enc #(
  parameter int NUM_SRC = 8,
  parameter int VEC_W   = 3
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [VEC_W-1:0]   idx,
  output logic               vld
);

  // Scan from the top down so the lowest set index is the last one assigned
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = VEC_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-latching, fixed-priority interrupt controller presenting one non-nested
// request/vector to the cpu with ack and end-of-interrupt handshakes.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int VEC_W   = VEC_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic               irq,
  output logic [VEC_W-1:0]   irq_vec,
  input  logic               irq_ack,
  input  logic               eoi,
  output logic [NUM_SRC-1:0] pending,
  output logic               in_service
);

  state_t             state;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] ack_clr;
  logic [VEC_W-1:0]   win_idx;
  logic               win_vld;
  logic               ack_ok;

  assign rise     = src & ~src_q;
  assign eligible = pending & ~mask;
  assign ack_ok   = (state == ST_REQ) && irq_ack;
  assign ack_clr  = ack_ok ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << irq_vec) : '0;

  assign irq        = (state == ST_REQ);
  assign in_service = (state == ST_SVC);

  prio_enc #(
    .NUM_SRC (NUM_SRC),
    .VEC_W   (VEC_W)
  ) u_prio (
    .req (eligible),
    .idx (win_idx),
    .vld (win_vld)
  );

  // Clear is applied before the new edges are OR'd in, so a same-cycle rise survives the ack
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      src_q   <= '0;
      pending <= '0;
      mask    <= '0;
    end else begin
      src_q   <= src;
      pending <= (pending & ~ack_clr) | rise;
      if (mask_we) mask <= mask_wdata;
    end
  end

  // irq_vec is captured only when leaving IDLE, then frozen through REQ and SVC
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      irq_vec <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            state   <= ST_REQ;
            irq_vec <= win_idx;
          end
        end
        ST_REQ:  if (irq_ack) state <= ST_SVC;
        ST_SVC:  if (eoi)     state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Randomized bench for irq_controller: a behavioural model predicts every cycle and
// queues the vector of each predicted request for an independent monitor.
module tb_irq_controller;

  localparam int N = 8;
  localparam int W = 3;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] src;
  logic         mask_we;
  logic [N-1:0] mask_wdata;
  logic         irq;
  logic [W-1:0] irq_vec;
  logic         irq_ack;
  logic         eoi;
  logic [N-1:0] pending;
  logic         in_service;

  int compared   = 0;
  int mismatched = 0;

  // Model: phase 0 = nothing outstanding, 1 = waiting for ack, 2 = being serviced
  bit [N-1:0] m_pend, m_mask, m_srcq;
  int         m_phase;
  int         m_vec;
  int         exp_q[$];

  irq_controller #(.NUM_SRC(N), .VEC_W(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .src        (src),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .irq        (irq),
    .irq_vec    (irq_vec),
    .irq_ack    (irq_ack),
    .eoi        (eoi),
    .pending    (pending),
    .in_service (in_service)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_mask  = '0;
    m_srcq  = '0;
    m_phase = 0;
    m_vec   = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    int win;
    win = -1;
    for (int i = 0; i < N; i++)
      if (m_pend[i] && !m_mask[i] && win < 0) win = i;
    case (m_phase)
      0: if (win >= 0) begin
           m_phase = 1;
           m_vec   = win;
           exp_q.push_back(win);
         end
      1: if (irq_ack) begin
           m_pend[m_vec] = 1'b0;
           m_phase = 2;
         end
      default: if (eoi) m_phase = 0;
    endcase
    for (int i = 0; i < N; i++)
      if (src[i] && !m_srcq[i]) m_pend[i] = 1'b1;
    if (mask_we) m_mask = mask_wdata;
    m_srcq = src;
  endtask

  task automatic check_outputs();
    chk("irq",        {31'd0, irq},        {31'd0, m_phase == 1});
    chk("in_service", {31'd0, in_service}, {31'd0, m_phase == 2});
    chk("irq_vec",    {29'd0, irq_vec},    m_vec);
    chk("pending",    {24'd0, pending},    {24'd0, m_pend});
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < N; i++)
      if ($urandom_range(5) == 0) src[i] = ~src[i];
    mask_we    = ($urandom_range(11) == 0);
    mask_wdata = N'($urandom & $urandom);
    irq_ack    = (m_phase == 1) ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0);
    eoi        = (m_phase == 2) ? ($urandom_range(3) == 0) : ($urandom_range(9) == 0);
    // Provoke a re-edge on the vector being acked in the same cycle
    if (m_phase == 1 && irq_ack && $urandom_range(1) == 0 && !m_srcq[m_vec])
      src[m_vec] = 1'b1;
    else if (m_phase == 1 && $urandom_range(3) == 0)
      src[m_vec] = 1'b0;
  endtask

  // Monitor: each new request must carry the next predicted vector
  initial begin
    logic prev_irq;
    int   e;
    prev_irq = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (irq === 1'b1 && prev_irq !== 1'b1) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL req_unexpected: got irq with vec %0d, expected no request at %0t", irq_vec, $time);
        end else begin
          e = exp_q.pop_front();
          chk("req_vec", {29'd0, irq_vec}, e);
        end
      end
      prev_irq = irq;
    end
  end

  initial begin
    int next_rst;
    reset      = 1'b0;
    src        = 8'hFF;
    mask_we    = 1'b0;
    mask_wdata = '0;
    irq_ack    = 1'b0;
    eoi        = 1'b0;
    model_reset();
    repeat (4) @(negedge clock);
    check_outputs();
    reset = 1'b1;
    next_rst = 200;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      model_step();
      @(negedge clock);
      check_outputs();
      if (cyc == 0) chk("release_pending", {24'd0, pending}, 32'hFF);
      if (cyc == 1) begin
        chk("release_irq", {31'd0, irq}, 32'd1);
        chk("release_vec", {29'd0, irq_vec}, 32'd0);
      end
      if (cyc >= next_rst && m_phase == 2) begin
        reset = 1'b0;
        #1;
        chk("rst_irq",        {31'd0, irq},        32'd0);
        chk("rst_in_service", {31'd0, in_service}, 32'd0);
        chk("rst_pending",    {24'd0, pending},    32'd0);
        model_reset();
        exp_q.delete();
        src     = (cyc % 2 == 0) ? 8'h00 : N'($urandom);
        irq_ack = 1'b0;
        eoi     = 1'b0;
        mask_we = 1'b0;
        repeat (2) @(negedge clock);
        check_outputs();
        reset    = 1'b1;
        next_rst = cyc + 300;
      end else begin
        randomize_inputs();
      end
    end

    @(posedge clock);
    #2;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
